key_conditioner: RTL and testbench

KEY_CONDITIONER -- requirements
Module: key_conditioner

---
 rtl/key_conditioner_pkg.sv | 42 ++++
 rtl/key_conditioner_btn_debounce.sv | 59 +++++
 rtl/key_conditioner.sv | 176 +++++++++++++++++
 tb/tb_key_conditioner.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_conditioner_pkg.sv
// Shared definitions for the key conditioner: keypad FSM encoding,
// default timing constants and keypad pattern helpers.
`timescale 1ns/1ps
package key_conditioner_pkg;

    // Keypad FSM state encoding
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DEB_PRESS = 2'd1,
        PRESSED   = 2'd2,
        DEB_REL   = 2'd3
    } kp_state_t;

    // Default timing, in clk cycles at 1 kHz
    localparam int DEF_DEB_CYC   = 20;
    localparam int DEF_RPT_DELAY = 500;
    localparam int DEF_RPT_RATE  = 100;

    localparam int KEY_N      = 10;
    localparam int KEY_CODE_W = 4;

    // Index of the highest set bit; only meaningful for a one-hot pattern
    function automatic logic [KEY_CODE_W-1:0] key_index(input logic [KEY_N-1:0] v);
        logic [KEY_CODE_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < KEY_N; i++) begin
            if (v[i]) idx = KEY_CODE_W'(i);
        end
        return idx;
    endfunction

    // Number of keypad lines currently active
    function automatic logic [3:0] key_count(input logic [KEY_N-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < KEY_N; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/key_conditioner_btn_debounce.sv
// Single push-button conditioner: 2-flop synchroniser, stability counter
// holding a debounced level, and a one-cycle pulse on each debounced press.
`timescale 1ns/1ps
module btn_debounce
    import key_conditioner_pkg::*;
#(
    parameter int DEB_CYC = DEF_DEB_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic pulse
);

    localparam int            CW       = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

    logic          sync_p0;
    logic          sync_p1;
    logic          level;
    logic [CW-1:0] cnt;

    // Saturating increment so the counter can never wrap
    function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] c);
        return (c == CNT_LAST) ? c : c + CW'(1);
    endfunction

    // Two-flop synchroniser for the asynchronous button line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
        end
    end

    // Level flips after DEB_CYC consecutive disagreeing samples; pulse on 0->1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level <= 1'b0;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            pulse <= 1'b0;
            if (sync_p1 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync_p1;
                cnt   <= '0;
                pulse <= sync_p1;
            end else begin
                cnt <= cnt_inc(cnt);
            end
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// Front-panel input conditioner: debounced mode/start buttons and a
// debounced 10-key keypad with single-key acceptance and auto-repeat.
`timescale 1ns/1ps
module key_conditioner
    import key_conditioner_pkg::*;
#(
    parameter int DEB_CYC   = DEF_DEB_CYC,
    parameter int RPT_DELAY = DEF_RPT_DELAY,
    parameter int RPT_RATE  = DEF_RPT_RATE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode_btn,
    input  logic                  start_btn,
    input  logic [KEY_N-1:0]      keypad_raw,
    output logic                  mode_pulse,
    output logic                  start_pulse,
    output logic                  key_valid,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  key_held,
    output logic                  multi_key_err
);

    localparam int            CW       = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [CW-1:0] DEB_FULL = CW'(DEB_CYC - 1);

    localparam int            RMAX      = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
    localparam int            RW        = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam logic [RW-1:0] DLY_LAST  = RW'(RPT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST = RW'(RPT_RATE - 1);
    localparam logic [RW-1:0] RCNT_SAT  = RW'(RMAX - 1);

    // Button paths are fully independent of the keypad path
    btn_debounce #(.DEB_CYC(DEB_CYC)) u_mode_deb (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (mode_btn),
        .pulse   (mode_pulse)
    );

    btn_debounce #(.DEB_CYC(DEB_CYC)) u_start_deb (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (start_btn),
        .pulse   (start_pulse)
    );

    logic [KEY_N-1:0]      kp_p0;
    logic [KEY_N-1:0]      kp_p1;

    kp_state_t             state, state_nx;
    logic [CW-1:0]         cnt, cnt_nx;
    logic [RW-1:0]         rcnt, rcnt_nx;
    logic                  rep, rep_nx;
    logic [KEY_N-1:0]      pat, pat_nx;
    logic [KEY_CODE_W-1:0] code_nx;
    logic                  valid_nx;
    logic                  match;
    logic [3:0]            n_keys;
    logic [RW-1:0]         rpt_last;

    // Saturating increments so neither counter can wrap
    function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] c);
        return (c == DEB_FULL) ? c : c + CW'(1);
    endfunction

    function automatic logic [RW-1:0] rcnt_inc(input logic [RW-1:0] c);
        return (c == RCNT_SAT) ? c : c + RW'(1);
    endfunction

    // Two-flop synchroniser for all keypad lines
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kp_p0 <= '0;
            kp_p1 <= '0;
        end else begin
            kp_p0 <= keypad_raw;
            kp_p1 <= kp_p0;
        end
    end

    assign match    = (kp_p1 == pat);
    assign n_keys   = key_count(kp_p1);
    // First repeat waits RPT_DELAY held cycles, later ones RPT_RATE
    assign rpt_last = rep ? RATE_LAST : DLY_LAST;

    // Keypad FSM next-state, counters and strobe decode
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        rcnt_nx  = rcnt;
        rep_nx   = rep;
        pat_nx   = pat;
        code_nx  = key_code;
        valid_nx = 1'b0;
        case (state)
            IDLE: begin
                if (n_keys == 4'd1) begin
                    pat_nx   = kp_p1;
                    cnt_nx   = '0;
                    state_nx = DEB_PRESS;
                end
            end
            DEB_PRESS: begin
                if (!match) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else if (cnt_inc(cnt) == DEB_FULL) begin
                    cnt_nx   = '0;
                    rcnt_nx  = '0;
                    rep_nx   = 1'b0;
                    valid_nx = 1'b1;
                    code_nx  = key_index(pat);
                    state_nx = PRESSED;
                end else begin
                    cnt_nx = cnt_inc(cnt);
                end
            end
            PRESSED: begin
                if (!match) begin
                    // Any other pattern, including a second key, starts release
                    cnt_nx   = '0;
                    state_nx = DEB_REL;
                end else if (rcnt == rpt_last) begin
                    rcnt_nx  = '0;
                    rep_nx   = 1'b1;
                    valid_nx = 1'b1;
                end else begin
                    rcnt_nx = rcnt_inc(rcnt);
                end
            end
            DEB_REL: begin
                if (match) begin
                    // Bounce back to the held key: restart the repeat schedule
                    cnt_nx   = '0;
                    rcnt_nx  = '0;
                    rep_nx   = 1'b0;
                    state_nx = PRESSED;
                end else if (cnt_inc(cnt) == DEB_FULL) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt_inc(cnt);
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Keypad FSM state, counters and registered strobe/code
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rcnt      <= '0;
            rep       <= 1'b0;
            pat       <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            rcnt      <= rcnt_nx;
            rep       <= rep_nx;
            pat       <= pat_nx;
            key_code  <= code_nx;
            key_valid <= valid_nx;
        end
    end

    assign key_held      = (state == PRESSED) || (state == DEB_REL);
    assign multi_key_err = (state == IDLE) && (n_keys > 4'd1);

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with default timing parameters.
`timescale 1ns/1ps
module tb_key_conditioner;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       mode_btn = 1'b0;
    logic       start_btn = 1'b0;
    logic [9:0] keypad_raw = '0;
    logic       mode_pulse;
    logic       start_pulse;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;
    logic       multi_key_err;

    int n_cmp = 0;
    int n_bad = 0;

    key_conditioner dut (
        .clk           (clk),
        .rst           (rst),
        .mode_btn      (mode_btn),
        .start_btn     (start_btn),
        .keypad_raw    (keypad_raw),
        .mode_pulse    (mode_pulse),
        .start_pulse   (start_pulse),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .key_held      (key_held),
        .multi_key_err (multi_key_err)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs set before a step are seen by that edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        mode_btn   = 1'b0;
        start_btn  = 1'b0;
        keypad_raw = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step();
        n_cmp++; if (mode_pulse !== 1'b0) begin n_bad++; $display("FAIL rst_mode_pulse: got %0b want 0", mode_pulse); end
        n_cmp++; if (start_pulse !== 1'b0) begin n_bad++; $display("FAIL rst_start_pulse: got %0b want 0", start_pulse); end
        n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL rst_key_valid: got %0b want 0", key_valid); end
        n_cmp++; if (key_code !== 4'd0) begin n_bad++; $display("FAIL rst_key_code: got %0d want 0", key_code); end
        n_cmp++; if (key_held !== 1'b0) begin n_bad++; $display("FAIL rst_key_held: got %0b want 0", key_held); end
        n_cmp++; if (multi_key_err !== 1'b0) begin n_bad++; $display("FAIL rst_multi_err: got %0b want 0", multi_key_err); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_mode_glitch();
        int npulse, first, nstart;
        npulse = 0; first = -1; nstart = 0;
        for (int c = 0; c < 60; c++) begin
            mode_btn = (c < 30) && !(c == 2 || c == 5 || c == 8);
            step();
            if (mode_pulse === 1'b1) begin npulse++; if (first < 0) first = c + 1; end
            if (start_pulse === 1'b1) nstart++;
        end
        n_cmp++; if (npulse !== 1) begin n_bad++; $display("FAIL glitch_pulse_count: got %0d want 1", npulse); end
        n_cmp++; if (first !== 31) begin n_bad++; $display("FAIL glitch_pulse_cycle: got %0d want 31", first); end
        n_cmp++; if (nstart !== 0) begin n_bad++; $display("FAIL glitch_start_leak: got %0d want 0", nstart); end
        idle(10);
    endtask

    task automatic test_mode_hold(input int len, input int exp_n, input int exp_first);
        int npulse, first;
        npulse = 0; first = -1;
        for (int c = 0; c < 60; c++) begin
            mode_btn = (c < len);
            step();
            if (mode_pulse === 1'b1) begin npulse++; if (first < 0) first = c + 1; end
        end
        n_cmp++; if (npulse !== exp_n) begin n_bad++; $display("FAIL hold%0d_pulse_count: got %0d want %0d", len, npulse, exp_n); end
        if (exp_n > 0) begin
            n_cmp++; if (first !== exp_first) begin n_bad++; $display("FAIL hold%0d_pulse_cycle: got %0d want %0d", len, first, exp_first); end
        end
        idle(10);
    endtask

    task automatic test_key_repeat();
        int nv, st[4], cd[4], rise, fall;
        logic prev;
        nv = 0; rise = -1; fall = -1; prev = 1'b0;
        for (int k = 0; k < 4; k++) begin st[k] = -1; cd[k] = -1; end
        for (int c = 0; c < 760; c++) begin
            keypad_raw = (c < 700) ? 10'b00_0010_0000 : 10'b0;
            step();
            if (key_valid === 1'b1) begin
                if (nv < 4) begin st[nv] = c + 1; cd[nv] = int'(key_code); end
                nv++;
            end
            if (key_held === 1'b1 && !prev && rise < 0) rise = c + 1;
            if (key_held === 1'b0 && prev && fall < 0) fall = c + 1;
            prev = key_held;
        end
        n_cmp++; if (nv !== 3) begin n_bad++; $display("FAIL rpt_strobe_count: got %0d want 3", nv); end
        n_cmp++; if (st[0] !== 22) begin n_bad++; $display("FAIL rpt_first_cycle: got %0d want 22", st[0]); end
        n_cmp++; if (cd[0] !== 5) begin n_bad++; $display("FAIL rpt_first_code: got %0d want 5", cd[0]); end
        n_cmp++; if (st[1] !== 522) begin n_bad++; $display("FAIL rpt_second_cycle: got %0d want 522", st[1]); end
        n_cmp++; if (st[2] !== 622) begin n_bad++; $display("FAIL rpt_third_cycle: got %0d want 622", st[2]); end
        n_cmp++; if (cd[2] !== 5) begin n_bad++; $display("FAIL rpt_third_code: got %0d want 5", cd[2]); end
        n_cmp++; if (rise !== 22) begin n_bad++; $display("FAIL rpt_held_rise: got %0d want 22", rise); end
        n_cmp++; if (fall !== 722) begin n_bad++; $display("FAIL rpt_held_fall: got %0d want 722", fall); end
        idle(10);
    endtask

    task automatic test_multi_key();
        int nv, nh;
        nv = 0; nh = 0;
        for (int c = 0; c < 50; c++) begin
            keypad_raw = (c < 40) ? 10'b00_0000_0011 : 10'b0;
            step();
            if (key_valid === 1'b1) nv++;
            if (key_held === 1'b1) nh++;
            if (c + 1 == 1) begin
                n_cmp++; if (multi_key_err !== 1'b0) begin n_bad++; $display("FAIL multi_err_c1: got %0b want 0", multi_key_err); end
            end
            if (c + 1 == 2) begin
                n_cmp++; if (multi_key_err !== 1'b1) begin n_bad++; $display("FAIL multi_err_c2: got %0b want 1", multi_key_err); end
            end
            if (c + 1 == 41) begin
                n_cmp++; if (multi_key_err !== 1'b1) begin n_bad++; $display("FAIL multi_err_c41: got %0b want 1", multi_key_err); end
            end
            if (c + 1 == 42) begin
                n_cmp++; if (multi_key_err !== 1'b0) begin n_bad++; $display("FAIL multi_err_c42: got %0b want 0", multi_key_err); end
            end
        end
        n_cmp++; if (nv !== 0) begin n_bad++; $display("FAIL multi_no_valid: got %0d want 0", nv); end
        n_cmp++; if (nh !== 0) begin n_bad++; $display("FAIL multi_no_held: got %0d want 0", nh); end
        idle(5);
    endtask

    task automatic test_key_bounce();
        int nv, nh;
        nv = 0; nh = 0;
        for (int c = 0; c < 40; c++) begin
            keypad_raw = (c < 10) ? 10'b00_0000_1000 : 10'b0;
            step();
            if (key_valid === 1'b1) nv++;
            if (key_held === 1'b1) nh++;
        end
        n_cmp++; if (nv !== 0) begin n_bad++; $display("FAIL bounce_no_valid: got %0d want 0", nv); end
        n_cmp++; if (nh !== 0) begin n_bad++; $display("FAIL bounce_no_held: got %0d want 0", nh); end
        idle(5);
    endtask

    task automatic test_key_switch();
        int nv, st[4], cd[4];
        nv = 0;
        for (int k = 0; k < 4; k++) begin st[k] = -1; cd[k] = -1; end
        for (int c = 0; c < 130; c++) begin
            if (c < 30)       keypad_raw = 10'b00_0000_0100;
            else if (c < 100) keypad_raw = 10'b00_0001_0000;
            else              keypad_raw = 10'b0;
            step();
            if (key_valid === 1'b1) begin
                if (nv < 4) begin st[nv] = c + 1; cd[nv] = int'(key_code); end
                nv++;
            end
            if (c + 1 == 51) begin
                n_cmp++; if (key_held !== 1'b1) begin n_bad++; $display("FAIL switch_held_c51: got %0b want 1", key_held); end
            end
            if (c + 1 == 52) begin
                n_cmp++; if (key_held !== 1'b0) begin n_bad++; $display("FAIL switch_held_c52: got %0b want 0", key_held); end
            end
        end
        n_cmp++; if (nv !== 2) begin n_bad++; $display("FAIL switch_strobe_count: got %0d want 2", nv); end
        n_cmp++; if (st[0] !== 22 || cd[0] !== 2) begin n_bad++; $display("FAIL switch_first: got cycle %0d code %0d want cycle 22 code 2", st[0], cd[0]); end
        n_cmp++; if (st[1] !== 72 || cd[1] !== 4) begin n_bad++; $display("FAIL switch_second: got cycle %0d code %0d want cycle 72 code 4", st[1], cd[1]); end
        idle(10);
    endtask

    task automatic test_reset_mid_press();
        int nv, first, code;
        nv = 0; first = -1; code = -1;
        for (int c = 0; c < 60; c++) begin
            keypad_raw = 10'b00_1000_0000;
            if (c == 12) rst = 1'b0;
            if (c == 15) rst = 1'b1;
            step();
            if (key_valid === 1'b1) begin nv++; if (first < 0) begin first = c + 1; code = int'(key_code); end end
            if (c + 1 == 14) begin
                n_cmp++; if (key_code !== 4'd0 || key_held !== 1'b0) begin n_bad++; $display("FAIL midrst_in_reset: got code %0d held %0b want code 0 held 0", key_code, key_held); end
            end
        end
        n_cmp++; if (nv !== 1) begin n_bad++; $display("FAIL midrst_strobe_count: got %0d want 1", nv); end
        n_cmp++; if (first !== 37) begin n_bad++; $display("FAIL midrst_strobe_cycle: got %0d want 37", first); end
        n_cmp++; if (code !== 7) begin n_bad++; $display("FAIL midrst_code: got %0d want 7", code); end
        idle(40);
    endtask

    task automatic test_simultaneous();
        int ns, nv, nm, s_at, v_at, code;
        ns = 0; nv = 0; nm = 0; s_at = -1; v_at = -1; code = -1;
        for (int c = 0; c < 60; c++) begin
            start_btn  = (c < 30);
            keypad_raw = (c < 30) ? 10'b10_0000_0000 : 10'b0;
            step();
            if (start_pulse === 1'b1) begin ns++; if (s_at < 0) s_at = c + 1; end
            if (key_valid === 1'b1) begin nv++; if (v_at < 0) begin v_at = c + 1; code = int'(key_code); end end
            if (mode_pulse === 1'b1) nm++;
        end
        n_cmp++; if (ns !== 1 || s_at !== 22) begin n_bad++; $display("FAIL simul_start: got %0d pulses at %0d want 1 at 22", ns, s_at); end
        n_cmp++; if (nv !== 1 || v_at !== 22) begin n_bad++; $display("FAIL simul_valid: got %0d strobes at %0d want 1 at 22", nv, v_at); end
        n_cmp++; if (code !== 9) begin n_bad++; $display("FAIL simul_code: got %0d want 9", code); end
        n_cmp++; if (nm !== 0) begin n_bad++; $display("FAIL simul_mode_leak: got %0d want 0", nm); end
        idle(10);
    endtask

    initial begin
        test_reset();
        test_mode_glitch();
        test_mode_hold(15, 0, 0);
        test_mode_hold(19, 0, 0);
        test_mode_hold(20, 1, 22);
        test_key_repeat();
        test_multi_key();
        test_key_bounce();
        test_key_switch();
        test_reset_mid_press();
        test_simultaneous();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
